ctrl_fsm: RTL and testbench

//  Multicycle control unit driving the integer datapath. Consumes decoded instruction

---
 rtl/ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_ctrl_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC/MWAIT -> WB sequencing
// and datapath control strobes for RV32I R-type plus M-extension MUL*.
module ctrl_fsm #(
    parameter int pcmux_N     = 2,
    parameter int ifuresctl_N = 2,
    parameter int MUL_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [1:0]                     func7b50,
    output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
    output logic                           pcnextctl,
    output logic                           instrre,
    output logic                           regre,
    output logic                           regwe,
    output logic [3:0]                     aluctl,
    output logic [1:0]                     mulctl,
    output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
    output logic                           illegal
);

    localparam int RW = $clog2(ifuresctl_N);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MWAIT  = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        C_ALU = 2'd0,
        C_MUL = 2'd1,
        C_ILL = 2'd2
    } cls_e;

    state_e        state_q, state_d;
    cls_e          cls_q, cls_d, cls_in;
    logic [2:0]    f3_q, f3_d;
    logic          f7h_q, f7h_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    alu_op;

    assign alu_op = {f7h_q, f3_q};

    // DIV/REM (func3[2]=1 with f7=01) stays illegal until a divider exists
    always_comb begin
        cls_in = C_ILL;
        if (opcode == 7'b0110011) begin
            if (func7b50 == 2'b00 ||
                (func7b50 == 2'b10 &&
                 (func3 == 3'b000 || func3 == 3'b101))) begin
                cls_in = C_ALU;
            end else if (func7b50 == 2'b01 && !func3[2]) begin
                cls_in = C_MUL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_ALU;
            f3_q    <= '0;
            f7h_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            f3_q    <= f3_d;
            f7h_q   <= f7h_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        f3_d    = f3_q;
        f7h_d   = f7h_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (run) state_d = S_DECODE;
            end
            S_DECODE: begin
                cls_d = cls_in;
                f3_d  = func3;
                f7h_d = func7b50[1];
                cnt_d = CW'(MUL_LAT - 1);
                case (cls_in)
                    C_ALU:   state_d = S_EXEC;
                    C_MUL:   state_d = S_MWAIT;
                    default: state_d = S_WB;
                endcase
            end
            S_EXEC: state_d = S_WB;
            S_MWAIT: begin
                if (cnt_q == '0) state_d = S_WB;
                else cnt_d = cnt_q - 1'b1;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Everything is held low while reset is asserted, whatever the state
    always_comb begin
        pcmuxctl  = '0;
        pcnextctl = 1'b0;
        instrre   = 1'b0;
        regre     = 1'b0;
        regwe     = 1'b0;
        aluctl    = '0;
        mulctl    = '0;
        ifuresctl = '0;
        illegal   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH:  instrre = run;
                S_DECODE: regre = 1'b1;
                S_EXEC:   aluctl = alu_op;
                S_MWAIT: begin
                    aluctl    = alu_op;
                    mulctl    = f3_q[1:0];
                    ifuresctl = RW'(1);
                end
                S_WB: begin
                    pcnextctl = 1'b1;
                    case (cls_q)
                        C_ALU: begin
                            regwe  = 1'b1;
                            aluctl = alu_op;
                        end
                        C_MUL: begin
                            regwe     = 1'b1;
                            aluctl    = alu_op;
                            mulctl    = f3_q[1:0];
                            ifuresctl = RW'(1);
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: per-cycle expected outputs are queued
// by the driver from an instruction-level model and popped by a monitor.
module tb_ctrl_fsm;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] func7b50;
    logic [0:0] pcmuxctl;
    logic       pcnextctl;
    logic       instrre;
    logic       regre;
    logic       regwe;
    logic [3:0] aluctl;
    logic [1:0] mulctl;
    logic [0:0] ifuresctl;
    logic       illegal;

    ctrl_fsm #(
        .pcmux_N    (2),
        .ifuresctl_N(2),
        .MUL_LAT    (L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .opcode   (opcode),
        .func3    (func3),
        .func7b50 (func7b50),
        .pcmuxctl (pcmuxctl),
        .pcnextctl(pcnextctl),
        .instrre  (instrre),
        .regre    (regre),
        .regwe    (regwe),
        .aluctl   (aluctl),
        .mulctl   (mulctl),
        .ifuresctl(ifuresctl),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcmux;
        logic       pcnext;
        logic       instrre;
        logic       regre;
        logic       regwe;
        logic [3:0] alu;
        logic [1:0] mul;
        logic       ifres;
        logic       ill;
    } vec_t;

    vec_t exp_q[$];
    vec_t act;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always_comb act = {pcmuxctl, pcnextctl, instrre, regre, regwe,
                       aluctl, mulctl, ifuresctl, illegal};

    always @(negedge clk) begin
        vec_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL outputs cyc=%0d got=%b want=%b (pcmux,pcnext,instrre,regre,regwe,alu4,mul2,ifres,ill)",
                         cyc, act, e);
            end
        end
    end

    // 0 = ALU, 1 = MUL, 2 = illegal
    function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [1:0] f7);
        if (op != 7'b0110011) return 2;
        if (f7 == 2'b00) return 0;
        if (f7 == 2'b10 && (f3 == 3'd0 || f3 == 3'd5)) return 0;
        if (f7 == 2'b01 && f3 < 3'd4) return 1;
        return 2;
    endfunction

    task automatic step(input logic r, input logic rn, input logic [6:0] op,
                        input logic [2:0] f3, input logic [1:0] f7,
                        input vec_t e);
        rst      = r;
        run      = rn;
        opcode   = op;
        func3    = f3;
        func7b50 = f7;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input logic r, input logic rn, input vec_t e);
        step(r, rn, 7'($urandom), 3'($urandom), 2'($urandom), e);
    endtask

    // abort: -1 none, -2 random cycle, otherwise reset on that cycle index
    task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                         input logic [1:0] f7, input int abort);
        vec_t seq[$];
        vec_t v;
        int   c = cls_of(op, f3, f7);
        int   ab = abort;
        v = '0; v.instrre = 1'b1; seq.push_back(v);
        v = '0; v.regre = 1'b1;   seq.push_back(v);
        if (c == 0) begin
            v = '0; v.alu = {f7[1], f3}; seq.push_back(v);
            v.pcnext = 1'b1; v.regwe = 1'b1; seq.push_back(v);
        end else if (c == 1) begin
            v = '0; v.alu = {1'b0, f3}; v.mul = f3[1:0]; v.ifres = 1'b1;
            for (int k = 0; k < L; k++) seq.push_back(v);
            v.pcnext = 1'b1; v.regwe = 1'b1; seq.push_back(v);
        end else begin
            v = '0; v.pcnext = 1'b1; v.ill = 1'b1; seq.push_back(v);
        end
        if (ab == -2) ab = $urandom_range(seq.size() - 1, 1);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == ab) begin
                noise(1'b1, 1'($urandom), '0);
                return;
            end
            if (i == 0) noise(1'b0, 1'b1, seq[i]);
            else if (i == 1) step(1'b0, 1'($urandom), op, f3, f7, seq[i]);
            else noise(1'b0, 1'($urandom), seq[i]);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = '0; func3 = '0; func7b50 = '0;
        @(posedge clk);
        #1;
        noise(1'b1, 1'b0, '0);
        noise(1'b1, 1'b0, '0);
        repeat (3) noise(1'b0, 1'b0, '0);

        instr(7'b0110011, 3'b000, 2'b10, -1);
        instr(7'b0110011, 3'b011, 2'b01, -1);
        instr(7'b0110011, 3'b100, 2'b01, -1);
        instr(7'b0010011, 3'b000, 2'b00, -1);
        instr(7'b0110011, 3'b001, 2'b10, -1);
        instr(7'b0110011, 3'b000, 2'b01, 2);
        instr(7'b0110011, 3'b101, 2'b10, -1);
        instr(7'b0110011, 3'b111, 2'b00, -1);

        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            repeat ($urandom_range(2, 0)) noise(1'b0, 1'b0, '0);
            op = ($urandom_range(3, 0) != 0) ? 7'b0110011 : 7'($urandom);
            instr(op, 3'($urandom), 2'($urandom),
                  ($urandom_range(9, 0) == 0) ? -2 : -1);
        end

        noise(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
